// File: rtl/pic_pkg.sv
// Shared types and bit positions for the 8259 command sequencer.
package pic_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ICW2,
    ST_ICW3,
    ST_ICW4,
    ST_READY
  } pic_state_t;

  // OCW2 R/SL/EOI encodings
  localparam logic [2:0] OCW2_ROT_AEOI_CLR = 3'b000;
  localparam logic [2:0] OCW2_NS_EOI       = 3'b001;
  localparam logic [2:0] OCW2_NOP          = 3'b010;
  localparam logic [2:0] OCW2_SP_EOI       = 3'b011;
  localparam logic [2:0] OCW2_ROT_AEOI_SET = 3'b100;
  localparam logic [2:0] OCW2_ROT_NS       = 3'b101;
  localparam logic [2:0] OCW2_SET_PRI      = 3'b110;
  localparam logic [2:0] OCW2_ROT_SP       = 3'b111;

  localparam int ICW1_IC4  = 0;
  localparam int ICW1_SNGL = 1;
  localparam int ICW1_LTIM = 3;
  localparam int CMD_D4    = 4;
  localparam int CMD_D3    = 3;

  localparam int ICW4_UPM  = 0;
  localparam int ICW4_AEOI = 1;
  localparam int ICW4_MS   = 2;
  localparam int ICW4_BUF  = 3;
  localparam int ICW4_SFNM = 4;

  localparam int OCW3_RIS  = 0;
  localparam int OCW3_RR   = 1;
  localparam int OCW3_P    = 2;
  localparam int OCW3_SMM  = 5;
  localparam int OCW3_ESMM = 6;

  // {wr, rd, a0, data[7:0]}
  localparam int BUS_W = 11;

  function automatic pic_state_t next_after_icw2(input logic sngl, input logic ic4);
    if (!sngl)    return ST_ICW3;
    else if (ic4) return ST_ICW4;
    else          return ST_READY;
  endfunction

endpackage

// File: rtl/pic_bus_sync.sv
// Bundle synchroniser: all bus bits move through the same flop chain so they stay aligned.
module pic_bus_sync #(
  parameter int WIDTH  = 11,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  generate
    if (STAGES == 0) begin : g_bypass
      assign o_q = i_d;
    end else begin : g_sync
      logic [STAGES-1:0][WIDTH-1:0] r_pipe;

      always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
          r_pipe <= '0;
        end else begin
          r_pipe[0] <= i_d;
          for (int i = 1; i < STAGES; i++) r_pipe[i] <= r_pipe[i-1];
        end
      end

      assign o_q = r_pipe[STAGES-1];
    end
  endgenerate

endmodule

// File: rtl/pic_command_sequencer.sv
// 8259 ICW1..ICW4 initialisation sequencer and OCW1..OCW3 decoder; holds programmed config.
module pic_command_sequencer
  import pic_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] IMR_RESET   = 8'h00
) (
  input  logic       clk,
  input  logic       rst_,
  input  logic       wr,
  input  logic       rd,
  input  logic       a0,
  input  logic [7:0] data_in,
  output logic       init_busy,
  output logic       ready,
  output logic       ltim,
  output logic       sngl,
  output logic [4:0] vector_base,
  output logic [7:0] icw3,
  output logic       aeoi,
  output logic       sfnm,
  output logic       buf_mode,
  output logic       ms,
  output logic       upm,
  output logic [7:0] imr,
  output logic       ocw2_valid,
  output logic [2:0] ocw2_cmd,
  output logic [2:0] ocw2_level,
  output logic       smm,
  output logic       read_isr,
  output logic       poll_req,
  output logic       rd_strobe
);

  logic [BUS_W-1:0] w_bus;
  logic             w_s_wr, w_s_rd, w_s_a0;
  logic [7:0]       w_s_data;

  pic_bus_sync #(.WIDTH(BUS_W), .STAGES(SYNC_STAGES)) u_sync (
    .clk  (clk),
    .rst_ (rst_),
    .i_d  ({wr, rd, a0, data_in}),
    .o_q  (w_bus)
  );

  assign {w_s_wr, w_s_rd, w_s_a0, w_s_data} = w_bus;

  logic       r_wr_d, r_rd_d, r_conflict;
  logic       r_a0;
  logic [7:0] r_data;

  // A write whose strobe ever overlapped rd is discarded at commit time.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_wr_d     <= 1'b0;
      r_rd_d     <= 1'b0;
      r_conflict <= 1'b0;
      r_a0       <= 1'b0;
      r_data     <= 8'h00;
    end else begin
      r_wr_d <= w_s_wr;
      r_rd_d <= w_s_rd;
      if (w_s_wr) begin
        r_a0   <= w_s_a0;
        r_data <= w_s_data;
      end
      if (w_s_wr && w_s_rd)        r_conflict <= 1'b1;
      else if (r_wr_d && !w_s_wr)  r_conflict <= 1'b0;
    end
  end

  logic w_commit, w_is_icw1, w_is_ocw2, w_is_ocw3;
  assign w_commit  = r_wr_d && !w_s_wr && !r_conflict;
  assign w_is_icw1 = !r_a0 &&  r_data[CMD_D4];
  assign w_is_ocw2 = !r_a0 && !r_data[CMD_D4] && !r_data[CMD_D3];
  assign w_is_ocw3 = !r_a0 && !r_data[CMD_D4] &&  r_data[CMD_D3];

  pic_state_t r_state;
  logic       r_ic4;
  logic       r_init_busy, r_ready, r_ltim, r_sngl;
  logic [4:0] r_vector_base;
  logic [7:0] r_icw3, r_imr;
  logic       r_aeoi, r_sfnm, r_buf, r_ms, r_upm;
  logic       r_ocw2_valid, r_poll_req, r_rd_strobe;
  logic [2:0] r_ocw2_cmd, r_ocw2_level;
  logic       r_smm, r_read_isr;

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_state       <= ST_IDLE;
      r_ic4         <= 1'b0;
      r_init_busy   <= 1'b0;
      r_ready       <= 1'b0;
      r_ltim        <= 1'b0;
      r_sngl        <= 1'b0;
      r_vector_base <= 5'h00;
      r_icw3        <= 8'h00;
      r_imr         <= IMR_RESET;
      r_aeoi        <= 1'b0;
      r_sfnm        <= 1'b0;
      r_buf         <= 1'b0;
      r_ms          <= 1'b0;
      r_upm         <= 1'b0;
      r_ocw2_valid  <= 1'b0;
      r_ocw2_cmd    <= 3'b000;
      r_ocw2_level  <= 3'b000;
      r_smm         <= 1'b0;
      r_read_isr    <= 1'b0;
      r_poll_req    <= 1'b0;
      r_rd_strobe   <= 1'b0;
    end else begin
      r_ocw2_valid <= 1'b0;
      r_poll_req   <= 1'b0;
      r_rd_strobe  <= w_s_rd && !r_rd_d && !w_s_wr;

      if (w_commit) begin
        if (w_is_icw1) begin
          // ICW1 restarts initialisation from any state
          r_ltim      <= r_data[ICW1_LTIM];
          r_sngl      <= r_data[ICW1_SNGL];
          r_ic4       <= r_data[ICW1_IC4];
          r_aeoi      <= 1'b0;
          r_sfnm      <= 1'b0;
          r_buf       <= 1'b0;
          r_ms        <= 1'b0;
          r_upm       <= 1'b0;
          r_imr       <= IMR_RESET;
          r_smm       <= 1'b0;
          r_read_isr  <= 1'b0;
          r_ready     <= 1'b0;
          r_init_busy <= 1'b1;
          r_state     <= ST_ICW2;
        end else begin
          unique case (r_state)
            ST_ICW2: if (r_a0) begin
              r_vector_base <= r_data[7:3];
              r_state       <= next_after_icw2(r_sngl, r_ic4);
              if (r_sngl && !r_ic4) begin
                r_init_busy <= 1'b0;
                r_ready     <= 1'b1;
              end
            end
            ST_ICW3: if (r_a0) begin
              r_icw3 <= r_data;
              if (r_ic4) begin
                r_state <= ST_ICW4;
              end else begin
                r_state     <= ST_READY;
                r_init_busy <= 1'b0;
                r_ready     <= 1'b1;
              end
            end
            ST_ICW4: if (r_a0) begin
              r_upm       <= r_data[ICW4_UPM];
              r_aeoi      <= r_data[ICW4_AEOI];
              r_ms        <= r_data[ICW4_MS];
              r_buf       <= r_data[ICW4_BUF];
              r_sfnm      <= r_data[ICW4_SFNM];
              r_state     <= ST_READY;
              r_init_busy <= 1'b0;
              r_ready     <= 1'b1;
            end
            ST_READY: begin
              if (r_a0) begin
                r_imr <= r_data;
              end else if (w_is_ocw2) begin
                r_ocw2_valid <= 1'b1;
                r_ocw2_cmd   <= r_data[7:5];
                r_ocw2_level <= r_data[2:0];
              end else if (w_is_ocw3) begin
                if (r_data[OCW3_ESMM]) r_smm      <= r_data[OCW3_SMM];
                if (r_data[OCW3_RR])   r_read_isr <= r_data[OCW3_RIS];
                if (r_data[OCW3_P])    r_poll_req <= 1'b1;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

  assign init_busy   = r_init_busy;
  assign ready       = r_ready;
  assign ltim        = r_ltim;
  assign sngl        = r_sngl;
  assign vector_base = r_vector_base;
  assign icw3        = r_icw3;
  assign aeoi        = r_aeoi;
  assign sfnm        = r_sfnm;
  assign buf_mode    = r_buf;
  assign ms          = r_ms;
  assign upm         = r_upm;
  assign imr         = r_imr;
  assign ocw2_valid  = r_ocw2_valid;
  assign ocw2_cmd    = r_ocw2_cmd;
  assign ocw2_level  = r_ocw2_level;
  assign smm         = r_smm;
  assign read_isr    = r_read_isr;
  assign poll_req    = r_poll_req;
  assign rd_strobe   = r_rd_strobe;

endmodule

// File: tb/tb_pic_command_sequencer.sv
// Directed bench for pic_command_sequencer with SYNC_STAGES=2.
module tb_pic_command_sequencer;

  logic       clk = 1'b0;
  logic       rst_ = 1'b0;
  logic       wr = 1'b0, rd = 1'b0, a0 = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       init_busy, ready, ltim, sngl;
  logic [4:0] vector_base;
  logic [7:0] icw3, imr;
  logic       aeoi, sfnm, buf_mode, ms, upm;
  logic       ocw2_valid, smm, read_isr, poll_req, rd_strobe;
  logic [2:0] ocw2_cmd, ocw2_level;

  int checks = 0;
  int errors = 0;
  int n_ocw2, n_poll, n_rds, k_ocw2, k_ready;
  logic [2:0] cap_cmd, cap_level;

  always #5 clk = ~clk;

  pic_command_sequencer #(.SYNC_STAGES(2), .IMR_RESET(8'h00)) dut (
    .clk(clk), .rst_(rst_), .wr(wr), .rd(rd), .a0(a0), .data_in(data_in),
    .init_busy(init_busy), .ready(ready), .ltim(ltim), .sngl(sngl),
    .vector_base(vector_base), .icw3(icw3), .aeoi(aeoi), .sfnm(sfnm),
    .buf_mode(buf_mode), .ms(ms), .upm(upm), .imr(imr),
    .ocw2_valid(ocw2_valid), .ocw2_cmd(ocw2_cmd), .ocw2_level(ocw2_level),
    .smm(smm), .read_isr(read_isr), .poll_req(poll_req), .rd_strobe(rd_strobe)
  );

  // Bus cycle; pulse outputs are tallied at each negedge after wr/rd drop (k = 1..7).
  task automatic bus_cycle(input logic w, input logic r, input logic a, input logic [7:0] d);
    n_ocw2 = 0; n_poll = 0; n_rds = 0; k_ocw2 = 0; k_ready = 0;
    @(negedge clk);
    wr = w; rd = r; a0 = a; data_in = d;
    repeat (2) @(negedge clk);
    wr = 1'b0; rd = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (ocw2_valid) begin
        n_ocw2++;
        if (k_ocw2 == 0) k_ocw2 = k;
        cap_cmd = ocw2_cmd; cap_level = ocw2_level;
      end
      if (poll_req)  n_poll++;
      if (rd_strobe) n_rds++;
      if (ready && k_ready == 0) k_ready = k;
    end
  endtask

  task automatic wr_cmd(input logic a, input logic [7:0] d);
    bus_cycle(1'b1, 1'b0, a, d);
  endtask

  task automatic test_reset;
    rst_ = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (init_busy !== 1'b0) begin errors++; $display("FAIL reset_init_busy got %b want 0", init_busy); end
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", ready); end
    checks++; if (imr !== 8'h00) begin errors++; $display("FAIL reset_imr got %h want 00", imr); end
    checks++; if ({ocw2_valid, poll_req, rd_strobe, smm, read_isr} !== 5'b0) begin
      errors++; $display("FAIL reset_pulses got %b want 00000", {ocw2_valid, poll_req, rd_strobe, smm, read_isr}); end
    rst_ = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_icw_sngl_ic4;
    wr_cmd(1'b0, 8'h13);
    checks++; if ({init_busy, ready, sngl, ltim} !== 4'b1010) begin
      errors++; $display("FAIL icw1_flags got %b want 1010", {init_busy, ready, sngl, ltim}); end
    wr_cmd(1'b1, 8'h40);
    checks++; if (vector_base !== 5'h08) begin errors++; $display("FAIL icw2_vector got %h want 08", vector_base); end
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL icw2_not_ready got %b want 0", ready); end
    wr_cmd(1'b1, 8'h03);
    checks++; if ({aeoi, upm, ms, buf_mode, sfnm} !== 5'b11000) begin
      errors++; $display("FAIL icw4_bits got %b want 11000", {aeoi, upm, ms, buf_mode, sfnm}); end
    checks++; if ({ready, init_busy} !== 2'b10) begin errors++; $display("FAIL icw4_ready got %b want 10", {ready, init_busy}); end
    checks++; if (k_ready !== 3) begin errors++; $display("FAIL commit_latency got %0d want 3", k_ready); end
    checks++; if (icw3 !== 8'h00) begin errors++; $display("FAIL icw3_skipped got %h want 00", icw3); end
  endtask

  task automatic test_icw_cascade;
    wr_cmd(1'b0, 8'h10);
    wr_cmd(1'b1, 8'h20);
    checks++; if ({init_busy, ready, vector_base} !== {2'b10, 5'h04}) begin
      errors++; $display("FAIL cascade_icw2 got %b/%b/%h want 1/0/04", init_busy, ready, vector_base); end
    checks++; if (aeoi !== 1'b0 || upm !== 1'b0) begin errors++; $display("FAIL icw1_clears_icw4 got %b%b want 00", aeoi, upm); end
    wr_cmd(1'b1, 8'h04);
    checks++; if (icw3 !== 8'h04) begin errors++; $display("FAIL icw3_value got %h want 04", icw3); end
    checks++; if ({init_busy, ready} !== 2'b01) begin errors++; $display("FAIL cascade_ready got %b want 01", {init_busy, ready}); end
  endtask

  task automatic test_ocw1;
    wr_cmd(1'b1, 8'hA5);
    checks++; if (imr !== 8'hA5) begin errors++; $display("FAIL ocw1_imr got %h want a5", imr); end
    wr_cmd(1'b0, 8'h10);
    checks++; if (imr !== 8'h00 || ready !== 1'b0 || init_busy !== 1'b1) begin
      errors++; $display("FAIL icw1_reinit got imr=%h ready=%b busy=%b want 00/0/1", imr, ready, init_busy); end
    wr_cmd(1'b1, 8'h20);
    wr_cmd(1'b1, 8'h04);
  endtask

  task automatic test_ocw2_ocw3;
    wr_cmd(1'b0, 8'h63);
    checks++; if (n_ocw2 !== 1 || k_ocw2 !== 3) begin
      errors++; $display("FAIL ocw2_pulse got count=%0d at=%0d want 1 at 3", n_ocw2, k_ocw2); end
    checks++; if (cap_cmd !== 3'b011 || cap_level !== 3'd3) begin
      errors++; $display("FAIL ocw2_fields got %b/%0d want 011/3", cap_cmd, cap_level); end
    wr_cmd(1'b0, 8'h0C);
    checks++; if (n_poll !== 1 || n_ocw2 !== 0) begin
      errors++; $display("FAIL ocw3_poll got poll=%0d ocw2=%0d want 1/0", n_poll, n_ocw2); end
    checks++; if (smm !== 1'b0 || read_isr !== 1'b0) begin errors++; $display("FAIL ocw3_noflags got %b%b want 00", smm, read_isr); end
    wr_cmd(1'b0, 8'h6B);
    checks++; if ({smm, read_isr, n_poll[0]} !== 3'b110) begin
      errors++; $display("FAIL ocw3_smm_ris got %b want 110", {smm, read_isr, n_poll[0]}); end
    wr_cmd(1'b0, 8'h20);
    wr_cmd(1'b0, 8'h20);
    checks++; if (n_ocw2 !== 1 || cap_cmd !== 3'b001) begin
      errors++; $display("FAIL ocw2_back_to_back got count=%0d cmd=%b want 1/001", n_ocw2, cap_cmd); end
    bus_cycle(1'b0, 1'b1, 1'b0, 8'h00);
    checks++; if (n_rds !== 1) begin errors++; $display("FAIL rd_strobe got %0d want 1", n_rds); end
  endtask

  task automatic test_restart_and_reset;
    wr_cmd(1'b0, 8'h13);
    wr_cmd(1'b0, 8'h10);
    wr_cmd(1'b1, 8'h88);
    checks++; if ({init_busy, ready, vector_base} !== {2'b10, 5'h11}) begin
      errors++; $display("FAIL restart_icw2 got %b/%b/%h want 1/0/11", init_busy, ready, vector_base); end
    @(negedge clk);
    rst_ = 1'b0;
    #1;
    checks++; if ({init_busy, ready, vector_base, sngl} !== 8'b0) begin
      errors++; $display("FAIL async_reset got %b want 0", {init_busy, ready, vector_base, sngl}); end
    @(negedge clk);
    rst_ = 1'b1;
    wr_cmd(1'b1, 8'h55);
    checks++; if (icw3 !== 8'h00 || imr !== 8'h00 || init_busy !== 1'b0) begin
      errors++; $display("FAIL post_reset_idle got icw3=%h imr=%h busy=%b want 00/00/0", icw3, imr, init_busy); end
  endtask

  task automatic test_idle_and_conflict;
    wr_cmd(1'b0, 8'h20);
    wr_cmd(1'b0, 8'h0C);
    checks++; if (n_poll !== 0 || ready !== 1'b0) begin
      errors++; $display("FAIL idle_ignore got poll=%0d ready=%b want 0/0", n_poll, ready); end
    wr_cmd(1'b0, 8'h12);
    wr_cmd(1'b1, 8'h08);
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL sngl_noic4_ready got %b want 1", ready); end
    bus_cycle(1'b1, 1'b1, 1'b1, 8'hFF);
    checks++; if (imr !== 8'h00 || n_rds !== 0) begin
      errors++; $display("FAIL wr_rd_conflict got imr=%h rds=%0d want 00/0", imr, n_rds); end
    bus_cycle(1'b1, 1'b1, 1'b0, 8'h20);
    checks++; if (n_ocw2 !== 0) begin errors++; $display("FAIL conflict_ocw2 got %0d want 0", n_ocw2); end
    wr_cmd(1'b1, 8'h3C);
    checks++; if (imr !== 8'h3C) begin errors++; $display("FAIL post_conflict_ocw1 got %h want 3c", imr); end
  endtask

  initial begin
    test_reset;
    test_icw_sngl_ic4;
    test_icw_cascade;
    test_ocw1;
    test_ocw2_ocw3;
    test_restart_and_reset;
    test_idle_and_conflict;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
